// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 8:1 mux scan reader.
// Contents: FSM state encoding, channel count, select width and
// settle counter width (covers settle values 0..15).
package mux_scan_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_capture_settle_timer.sv
// settle_timer: loadable down-counter that paces each mux channel.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the count
//   load  - reload the count with SETTLE (has priority over counting)
//   zero  - high while the count is zero
// The count saturates at zero; it only leaves zero through a load.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(SETTLE);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps the select of an 8:1 single-bit mux through
// channels 0..7, waits SETTLE cycles on each, samples Y, and hands the
// assembled byte downstream with a valid/ready handshake.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - request one 8-channel scan (IDLE, or HOLD together with ready)
//   Y     - mux output, synchronous to clk
//   X     - mux select
//   busy  - high from start acceptance until the byte is handed off
//   Q     - captured word, Q[i] = Y sampled while X == i
//   valid - Q holds a completed scan
//   ready - downstream accepts Q on valid && ready
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Y,
    output logic [SEL_W-1:0] X,
    output logic             busy,
    output logic [N_CH-1:0]  Q,
    output logic             valid,
    input  logic             ready
);

    state_t          state_q;
    state_t          state_d;
    logic [N_CH-1:0] staging;
    logic            zero;
    logic            load;
    logic            accept;
    logic            sample;
    logic            advance;
    logic            complete;
    logic            handoff;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        accept   = 1'b0;
        sample   = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;
        handoff  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (zero) begin
                    sample = 1'b1;
                    if (X != SEL_W'(N_CH - 1)) begin
                        advance = 1'b1;
                        load    = 1'b1;
                    end else begin
                        complete = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                // A start is only honoured when the current word leaves
                // in the same cycle; the restart skips IDLE entirely.
                if (valid && ready) begin
                    handoff = 1'b1;
                    if (start) begin
                        load    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X       <= '0;
            Q       <= '0;
            staging <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                X    <= '0;
                busy <= 1'b1;
            end
            if (sample) begin
                staging[X] <= Y;
            end
            if (advance) begin
                X <= X + SEL_W'(1);
            end
            // The last channel's sample goes straight into Q so the word
            // is complete on the same edge that raises valid.
            if (complete) begin
                Q     <= {Y, staging[N_CH-2:0]};
                valid <= 1'b1;
            end
            if (handoff) begin
                valid <= 1'b0;
                X     <= '0;
                busy  <= start;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_capture.sv
module tb_mux_scan_capture;

    logic       clk;
    logic       rst_n;
    logic       start1, ready1, start0, ready0;
    logic [7:0] d1, d0;
    logic [7:0] q1, q0;
    logic [2:0] x1, x0;
    logic       y1, y0;
    logic       busy1, busy0, valid1, valid0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic [7:0] q_exp;
        string      name;
    } vec_t;

    vec_t vecs[5];

    // behavioural 8:1 mux feeding each reader
    assign y1 = d1[x1];
    assign y0 = d0[x0];

    mux_scan_capture #(.SETTLE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .Y     (y1),
        .X     (x1),
        .busy  (busy1),
        .Q     (q1),
        .valid (valid1),
        .ready (ready1)
    );

    mux_scan_capture #(.SETTLE(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .Y     (y0),
        .X     (x0),
        .busy  (busy0),
        .Q     (q0),
        .valid (valid0),
        .ready (ready0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the negedge following the start-accept edge (j=0).
    // Walks the 16-cycle SETTLE=1 scan and checks the completed word.
    task automatic track_scan1(input logic [7:0] qexp, input logic [7:0] qprev, input string nm);
        for (int j = 0; j < 16; j++) begin
            check({nm, "_x"}, x1, j / 2);
            check({nm, "_busy_valid"}, {busy1, valid1}, 2'b10);
            check({nm, "_q_hold"}, q1, qprev);
            @(negedge clk);
        end
        check({nm, "_valid_at16"}, {busy1, valid1}, 2'b11);
        check({nm, "_q"}, q1, qexp);
        check({nm, "_x_last"}, x1, 3'd7);
    endtask

    task automatic scan1(input logic [7:0] d, input logic [7:0] qexp, input string nm);
        logic [7:0] qprev;
        qprev = q1;
        d1 = d;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        track_scan1(qexp, qprev, nm);
    endtask

    task automatic release1(input string nm);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check({nm, "_release"}, {busy1, valid1, x1}, 5'b0);
    endtask

    initial begin
        vecs[0] = '{d: 8'hAA, q_exp: 8'hAA, name: "scan_aa"};
        vecs[1] = '{d: 8'h00, q_exp: 8'h00, name: "scan_00"};
        vecs[2] = '{d: 8'hFF, q_exp: 8'hFF, name: "scan_ff"};
        vecs[3] = '{d: 8'h81, q_exp: 8'h81, name: "scan_81"};
        vecs[4] = '{d: 8'h96, q_exp: 8'h96, name: "scan_96"};

        rst_n  = 1'b1;
        start1 = 1'b1;
        start0 = 1'b1;
        ready1 = 1'b0;
        ready0 = 1'b0;
        d1     = 8'h00;
        d0     = 8'h00;

        // reset asserted mid-clock with start held high
        #12 rst_n = 1'b0;
        #1;
        check("rst_async_dut1", {x1, q1, valid1, busy1}, 13'h0);
        check("rst_async_dut0", {x0, q0, valid0, busy0}, 13'h0);
        repeat (3) begin
            @(negedge clk);
            check("rst_held_dut1", {x1, q1, valid1, busy1}, 13'h0);
        end
        start1 = 1'b0;
        start0 = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {x1, q1, valid1, busy1}, 13'h0);

        // table of single scans, each handed off immediately
        for (int i = 0; i < 5; i++) begin
            scan1(vecs[i].d, vecs[i].q_exp, vecs[i].name);
            release1(vecs[i].name);
        end

        // backpressure: start pulses in HOLD without ready are ignored
        scan1(8'hAA, 8'hAA, "bp_scan");
        for (int k = 0; k < 5; k++) begin
            ready1 = 1'b0;
            start1 = (k % 2 == 0);
            @(negedge clk);
            check("bp_hold", {busy1, valid1, x1, q1}, {2'b11, 3'd7, 8'hAA});
        end
        start1 = 1'b0;
        release1("bp");

        // back-to-back: ready and start together in HOLD restart directly
        scan1(8'hAA, 8'hAA, "b2b_first");
        d1     = 8'h3C;
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        start1 = 1'b0;
        track_scan1(8'h3C, 8'hAA, "b2b_second");
        release1("b2b");

        // reset in the middle of a scan while X == 4
        d1 = 8'h0F;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_x_before", x1, 3'd4);
        check("midrst_q_kept", q1, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clear", {x1, q1, valid1, busy1}, 13'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {x1, q1, valid1, busy1}, 13'h0);
        scan1(8'hAA, 8'hAA, "midrst_rescan");
        release1("midrst");

        // SETTLE=0 build: X moves every cycle, valid after 8 cycles
        d0 = 8'h5A;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("s0_x", x0, j);
            check("s0_busy_valid", {busy0, valid0}, 2'b10);
            @(negedge clk);
        end
        check("s0_valid_at8", {busy0, valid0}, 2'b11);
        check("s0_q", q0, 8'h5A);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        check("s0_release", {busy0, valid0, x0}, 5'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
